// File: rtl/mem_top.sv
// Memory-access pipeline stage: word loads/stores over an async-ready bus,
// misalignment detection, forwarding of the next result and the MEM/WB register.
module mem_top #(
    parameter logic [2:0] EXP_MISS_ALIGN = 3'd5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        int_detect,
    input  logic [29:0] ex_pc,
    input  logic        ex_en,
    input  logic        ex_br_flag,
    input  logic [1:0]  ex_mem_op,
    input  logic [31:0] ex_mem_wr_data,
    input  logic [1:0]  ex_ctrl_op,
    input  logic [4:0]  ex_dst_addr,
    input  logic        ex_gpr_we_,
    input  logic [2:0]  ex_exp_code,
    input  logic [31:0] ex_out,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy_,
    output logic        bus_as_,
    output logic        bus_rw,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wr_data,
    output logic        busy,
    output logic [31:0] fwd_data,
    output logic [29:0] mem_pc,
    output logic        mem_en,
    output logic        mem_br_flag,
    output logic [1:0]  mem_ctrl_op,
    output logic [4:0]  mem_dst_addr,
    output logic        mem_gpr_we_,
    output logic [2:0]  mem_exp_code,
    output logic [31:0] mem_out
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]  state_r;
    logic [0:0]  state_nxt_s;
    logic [29:0] addr_r;
    logic        rw_r;
    logic [31:0] wdata_r;
    logic        req_s;
    logic        miss_s;
    logic        acc_s;
    logic        is_load_s;
    logic        load_done_s;
    logic        busy_s;

    // Classify the instruction currently presented by EX/MEM.
    always_comb begin
        is_load_s = (ex_mem_op == 2'b01);
        req_s     = ex_en & (ex_exp_code == 3'd0) & ((ex_mem_op == 2'b01) | (ex_mem_op == 2'b10))
                    & ~flush & ~int_detect;
        miss_s    = req_s & (ex_out[1:0] != 2'b00);
        acc_s     = req_s & ~miss_s;
    end

    // Bus drive and next state; reset forces the bus idle without waiting for a clock.
    always_comb begin
        bus_as_     = 1'b1;
        bus_rw      = 1'b1;
        bus_addr    = 30'd0;
        bus_wr_data = 32'd0;
        busy_s      = 1'b0;
        load_done_s = 1'b0;
        state_nxt_s = state_r;
        if (reset) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (acc_s) begin
                        bus_as_     = 1'b0;
                        bus_rw      = is_load_s;
                        bus_addr    = ex_out[31:2];
                        bus_wr_data = ex_mem_wr_data;
                        busy_s      = bus_rdy_;
                        load_done_s = ~bus_rdy_ & is_load_s;
                        state_nxt_s = bus_rdy_ ? ST_ACCESS : ST_IDLE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    bus_as_     = 1'b0;
                    bus_rw      = rw_r;
                    bus_addr    = addr_r;
                    bus_wr_data = wdata_r;
                    busy_s      = bus_rdy_;
                    load_done_s = ~bus_rdy_ & rw_r;
                    state_nxt_s = bus_rdy_ ? ST_ACCESS : ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Forwarded value is exactly what mem_out will capture.
    always_comb begin
        busy = busy_s;
        if (load_done_s) begin
            fwd_data = bus_rd_data;
        end else if (miss_s) begin
            fwd_data = 32'd0;
        end else begin
            fwd_data = ex_out;
        end
    end

    // FSM state plus a copy of the bus request so a wait-stated cycle stays stable on the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            addr_r  <= 30'd0;
            rw_r    <= 1'b1;
            wdata_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_IDLE) && acc_s && bus_rdy_) begin
                addr_r  <= ex_out[31:2];
                rw_r    <= is_load_s;
                wdata_r <= ex_mem_wr_data;
            end
        end
    end

    // MEM/WB register: stall holds, flush/interrupt clears, an outstanding access inserts a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_pc       <= 30'd0;
            mem_en       <= 1'b0;
            mem_br_flag  <= 1'b0;
            mem_ctrl_op  <= 2'b00;
            mem_dst_addr <= 5'd0;
            mem_gpr_we_  <= 1'b1;
            mem_exp_code <= 3'd0;
            mem_out      <= 32'd0;
        end else if (stall) begin
            mem_pc       <= mem_pc;
        end else if (flush | int_detect | busy_s) begin
            mem_pc       <= 30'd0;
            mem_en       <= 1'b0;
            mem_br_flag  <= 1'b0;
            mem_ctrl_op  <= 2'b00;
            mem_dst_addr <= 5'd0;
            mem_gpr_we_  <= 1'b1;
            mem_exp_code <= 3'd0;
            mem_out      <= 32'd0;
        end else begin
            mem_pc       <= ex_pc;
            mem_en       <= ex_en;
            mem_br_flag  <= ex_br_flag;
            mem_ctrl_op  <= ex_ctrl_op;
            mem_dst_addr <= ex_dst_addr;
            mem_gpr_we_  <= miss_s ? 1'b1 : ex_gpr_we_;
            mem_exp_code <= miss_s ? EXP_MISS_ALIGN : ex_exp_code;
            mem_out      <= fwd_data;
        end
    end

endmodule

// File: tb/tb_mem_top.sv
// Self-checking bench for mem_top: directed cases with literal expectations,
// then randomized traffic compared against a transaction-level model.
module tb_mem_top;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, int_detect;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag;
    logic [1:0]  ex_mem_op;
    logic [31:0] ex_mem_wr_data;
    logic [1:0]  ex_ctrl_op;
    logic [4:0]  ex_dst_addr;
    logic        ex_gpr_we_;
    logic [2:0]  ex_exp_code;
    logic [31:0] ex_out;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;
    logic        bus_as_, bus_rw, busy;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data, fwd_data;
    logic [29:0] mem_pc;
    logic        mem_en, mem_br_flag, mem_gpr_we_;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;

    mem_top dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .int_detect(int_detect),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
        .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
        .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .bus_as_(bus_as_), .bus_rw(bus_rw),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .busy(busy), .fwd_data(fwd_data),
        .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
        .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
        .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] pc;
        logic        en;
        logic        br;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        we_;
        logic [2:0]  exp;
        logic [31:0] out;
    } wb_t;

    localparam wb_t WB_CLEAR = '{pc: 30'd0, en: 1'b0, br: 1'b0, ctrl: 2'd0, dst: 5'd0,
                                 we_: 1'b1, exp: 3'd0, out: 32'd0};

    int checks = 0;
    int errors = 0;

    // Model state: the MEM/WB contents and the outstanding bus transaction, if any.
    wb_t         m_wb, n_wb;
    logic        pend, n_pend;
    logic        p_rw, n_rw;
    logic [29:0] p_addr, n_addr;
    logic [31:0] p_data, n_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        stall = 1'b0; flush = 1'b0; int_detect = 1'b0;
        ex_pc = 30'd0; ex_en = 1'b0; ex_br_flag = 1'b0; ex_mem_op = 2'b00;
        ex_mem_wr_data = 32'd0; ex_ctrl_op = 2'b00; ex_dst_addr = 5'd0;
        ex_gpr_we_ = 1'b1; ex_exp_code = 3'd0; ex_out = 32'd0;
        bus_rd_data = 32'd0; bus_rdy_ = 1'b0;
    endtask

    // Called just after a posedge with inputs set: checks bus-side outputs and plans the next edge.
    task automatic settle();
        logic req, miss, acc, ld, e_as, e_rw, e_busy;
        logic [29:0] e_addr;
        logic [31:0] e_wd, e_fwd;
        #3;
        req  = ex_en && (ex_exp_code == 3'd0) && (ex_mem_op == 2'b01 || ex_mem_op == 2'b10)
               && !flush && !int_detect;
        miss = req && (ex_out[1:0] != 2'b00);
        acc  = req && !miss;
        e_as = 1'b1; e_rw = 1'b1; e_addr = 30'd0; e_wd = 32'd0; e_busy = 1'b0; ld = 1'b0;
        if (pend) begin
            e_as = 1'b0; e_rw = p_rw; e_addr = p_addr; e_wd = p_data;
            e_busy = bus_rdy_; ld = !bus_rdy_ && p_rw;
        end else if (acc) begin
            e_as = 1'b0; e_rw = (ex_mem_op == 2'b01); e_addr = ex_out[31:2]; e_wd = ex_mem_wr_data;
            e_busy = bus_rdy_; ld = !bus_rdy_ && e_rw;
        end
        e_fwd = ld ? bus_rd_data : (miss ? 32'd0 : ex_out);
        chk("bus_as_", {31'd0, bus_as_}, {31'd0, e_as});
        chk("bus_rw", {31'd0, bus_rw}, {31'd0, e_rw});
        chk("bus_addr", {2'd0, bus_addr}, {2'd0, e_addr});
        chk("bus_wr_data", bus_wr_data, e_wd);
        chk("busy", {31'd0, busy}, {31'd0, e_busy});
        chk("fwd_data", fwd_data, e_fwd);
        if (stall) n_wb = m_wb;
        else if (flush || int_detect || e_busy) n_wb = WB_CLEAR;
        else n_wb = '{pc: ex_pc, en: ex_en, br: ex_br_flag, ctrl: ex_ctrl_op, dst: ex_dst_addr,
                      we_: miss ? 1'b1 : ex_gpr_we_, exp: miss ? 3'd5 : ex_exp_code, out: e_fwd};
        n_pend = pend; n_rw = p_rw; n_addr = p_addr; n_data = p_data;
        if (pend) n_pend = bus_rdy_;
        else if (acc && bus_rdy_) begin
            n_pend = 1'b1; n_rw = (ex_mem_op == 2'b01); n_addr = ex_out[31:2]; n_data = ex_mem_wr_data;
        end
    endtask

    // Advances one clock and checks the MEM/WB register against the model.
    task automatic tick();
        @(posedge clk);
        m_wb = n_wb; pend = n_pend; p_rw = n_rw; p_addr = n_addr; p_data = n_data;
        #1;
        chk("mem_pc", {2'd0, mem_pc}, {2'd0, m_wb.pc});
        chk("mem_en", {31'd0, mem_en}, {31'd0, m_wb.en});
        chk("mem_br_flag", {31'd0, mem_br_flag}, {31'd0, m_wb.br});
        chk("mem_ctrl_op", {30'd0, mem_ctrl_op}, {30'd0, m_wb.ctrl});
        chk("mem_dst_addr", {27'd0, mem_dst_addr}, {27'd0, m_wb.dst});
        chk("mem_gpr_we_", {31'd0, mem_gpr_we_}, {31'd0, m_wb.we_});
        chk("mem_exp_code", {29'd0, mem_exp_code}, {29'd0, m_wb.exp});
        chk("mem_out", mem_out, m_wb.out);
    endtask

    task automatic randomize_inputs();
        logic [31:0] v;
        if (!pend) begin
            ex_pc = 30'($urandom); ex_en = ($urandom_range(9) != 0); ex_br_flag = 1'($urandom);
            ex_mem_op = 2'($urandom); ex_mem_wr_data = $urandom; ex_ctrl_op = 2'($urandom);
            ex_dst_addr = 5'($urandom); ex_gpr_we_ = 1'($urandom);
            ex_exp_code = ($urandom_range(3) == 0) ? 3'($urandom) : 3'd0;
            v = $urandom;
            if ($urandom_range(3) != 0) v[1:0] = 2'b00;
            ex_out = v;
        end
        stall = ($urandom_range(7) == 0);
        flush = ($urandom_range(9) == 0);
        int_detect = ($urandom_range(15) == 0);
        bus_rdy_ = 1'($urandom);
        bus_rd_data = $urandom;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        m_wb = WB_CLEAR; pend = 1'b0; p_rw = 1'b1; p_addr = 30'd0; p_data = 32'd0;
        #12;
        chk("rst mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst mem_gpr_we_", {31'd0, mem_gpr_we_}, 32'd1);
        chk("rst mem_out", mem_out, 32'd0);
        chk("rst bus_as_", {31'd0, bus_as_}, 32'd1);
        chk("rst busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Load, zero wait states.
        idle_inputs();
        ex_en = 1'b1; ex_mem_op = 2'b01; ex_out = 32'h0000_0104; ex_gpr_we_ = 1'b0;
        ex_dst_addr = 5'd3; bus_rdy_ = 1'b0; bus_rd_data = 32'hDEAD_BEEF;
        settle();
        chk("ld0 bus_addr", {2'd0, bus_addr}, 32'h41);
        chk("ld0 bus_rw", {31'd0, bus_rw}, 32'd1);
        chk("ld0 busy", {31'd0, busy}, 32'd0);
        tick();
        chk("ld0 mem_out", mem_out, 32'hDEAD_BEEF);
        chk("ld0 mem_en", {31'd0, mem_en}, 32'd1);

        // Store with two wait states.
        idle_inputs();
        ex_en = 1'b1; ex_mem_op = 2'b10; ex_out = 32'h200; ex_mem_wr_data = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            bus_rdy_ = (i < 2);
            settle();
            chk("st bus_as_", {31'd0, bus_as_}, 32'd0);
            chk("st bus_rw", {31'd0, bus_rw}, 32'd0);
            chk("st busy", {31'd0, busy}, (i < 2) ? 32'd1 : 32'd0);
            tick();
            chk("st mem_en", {31'd0, mem_en}, (i < 2) ? 32'd0 : 32'd1);
        end
        chk("st mem_out", mem_out, 32'h200);

        // Misaligned load.
        idle_inputs();
        ex_en = 1'b1; ex_mem_op = 2'b01; ex_out = 32'h0000_0102; ex_gpr_we_ = 1'b0;
        settle();
        chk("mis bus_as_", {31'd0, bus_as_}, 32'd1);
        tick();
        chk("mis exp", {29'd0, mem_exp_code}, 32'd5);
        chk("mis we_", {31'd0, mem_gpr_we_}, 32'd1);
        chk("mis out", mem_out, 32'd0);

        // Non-memory op.
        idle_inputs();
        ex_en = 1'b1; ex_out = 32'h0000_00AA; ex_gpr_we_ = 1'b0; ex_dst_addr = 5'd7;
        settle();
        chk("alu bus_as_", {31'd0, bus_as_}, 32'd1);
        chk("alu fwd", fwd_data, 32'hAA);
        tick();
        chk("alu mem_out", mem_out, 32'hAA);
        chk("alu dst", {27'd0, mem_dst_addr}, 32'd7);

        // Flush with a pending load in IDLE.
        idle_inputs();
        ex_en = 1'b1; ex_mem_op = 2'b01; ex_out = 32'h104; flush = 1'b1;
        settle();
        chk("fl_idle bus_as_", {31'd0, bus_as_}, 32'd1);
        tick();
        chk("fl_idle mem_en", {31'd0, mem_en}, 32'd0);

        // Flush during ACCESS: bus cycle still finishes.
        idle_inputs();
        ex_en = 1'b1; ex_mem_op = 2'b01; ex_out = 32'h300; bus_rdy_ = 1'b1;
        settle(); tick();
        flush = 1'b1;
        settle();
        chk("fl_acc bus_as_ wait", {31'd0, bus_as_}, 32'd0);
        tick();
        bus_rdy_ = 1'b0;
        settle();
        chk("fl_acc bus_as_ done", {31'd0, bus_as_}, 32'd0);
        chk("fl_acc busy", {31'd0, busy}, 32'd0);
        tick();
        chk("fl_acc mem_en", {31'd0, mem_en}, 32'd0);

        // Reset asserted mid-ACCESS acts without a clock edge.
        idle_inputs();
        ex_en = 1'b1; ex_mem_op = 2'b10; ex_out = 32'h400; bus_rdy_ = 1'b1;
        settle(); tick();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_acc bus_as_", {31'd0, bus_as_}, 32'd1);
        chk("rst_acc busy", {31'd0, busy}, 32'd0);
        chk("rst_acc mem_gpr_we_", {31'd0, mem_gpr_we_}, 32'd1);
        m_wb = WB_CLEAR; pend = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        idle_inputs();
        settle(); tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            settle();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_top.md
Name: mem_top

Overview:
- Memory-access stage of the CPU pipeline; consumes the EX/MEM pipeline register and produces the MEM/WB pipeline register.
- Executes word loads and stores over a single-master, asynchronous-ready bus.
- Raises a stall request while an access is outstanding.
- Detects misaligned accesses and drives a forwarding path back to decode.

Parameters:
- EXP_MISS_ALIGN, 3'd5, exception code written for a misaligned load/store.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- stall  in  1  pipeline stall from controller; hold MEM/WB register
- flush  in  1  pipeline flush; clear MEM/WB register
- int_detect  in  1  interrupt accepted; treated as flush
- ex_pc  in  30  word PC of the instruction in MEM
- ex_en  in  1  instruction valid
- ex_br_flag  in  1  branch-delay flag
- ex_mem_op  in  2  00 none, 01 load word, 10 store word, 11 reserved (treated as none)
- ex_mem_wr_data  in  32  store data
- ex_ctrl_op  in  2  control op, passed through
- ex_dst_addr  in  5  destination GPR
- ex_gpr_we_  in  1  GPR write enable, active low
- ex_exp_code  in  3  upstream exception code, 0 = none
- ex_out  in  32  ALU result; byte address for load/store
- bus_rd_data  in  32  read data, valid when bus_rdy_ = 0
- bus_rdy_  in  1  bus ready, active low
- bus_as_  out  1  address strobe, active low
- bus_rw  out  1  1 = read, 0 = write
- bus_addr  out  30  word address = ex_out[31:2]
- bus_wr_data  out  32  = ex_mem_wr_data
- busy  out  1  stall request to controller
- fwd_data  out  32  next mem_out value, for forwarding
- mem_pc  out  30  MEM/WB register output
- mem_en  out  1  MEM/WB register output
- mem_br_flag  out  1  MEM/WB register output
- mem_ctrl_op  out  2  MEM/WB register output
- mem_dst_addr  out  5  MEM/WB register output
- mem_gpr_we_  out  1  MEM/WB register output
- mem_exp_code  out  3  MEM/WB register output
- mem_out  out  32  MEM/WB register output

Behaviour:
- Access request: req = ex_en & ex_exp_code==0 & ex_mem_op in {01,10} & !flush & !int_detect.
- Misaligned: miss = req & ex_out[1:0]!=0. A misaligned access never strobes the bus.
- Valid access: acc = req & !miss.
- FSM has two states, IDLE and ACCESS.
  - IDLE: if acc, drive bus_as_=0, bus_rw=(op==load), bus_addr, bus_wr_data.
    - bus_rdy_=0 in the same cycle: access completes (1-cycle latency), busy=0, stay in IDLE.
    - bus_rdy_=1: busy=1, go to ACCESS.
  - ACCESS: keep bus_as_=0 with the same address, rw and data; ex_* is held by the stall.
    - busy = bus_rdy_.
    - On bus_rdy_=0: complete, go to IDLE.
    - flush and int_detect do not abort ACCESS; the bus cycle always finishes.
- When no access is driven: bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0.
- fwd_data / next mem_out:
  - load completing this cycle: bus_rd_data
  - miss: 0
  - otherwise: ex_out
- Next mem_exp_code: miss ? EXP_MISS_ALIGN : ex_exp_code.
- Next mem_gpr_we_: miss ? 1 : ex_gpr_we_.
- MEM/WB register update priority, on posedge clk:
  1. stall: hold all.
  2. flush | int_detect: clear (mem_en=0, mem_gpr_we_=1, all other fields 0).
  3. busy: bubble (same values as clear).
  4. otherwise: load the next values; remaining fields copy their ex_* counterparts.
- Reset (asynchronous, any state including mid-ACCESS):
  - FSM goes to IDLE and bus_as_=1 immediately.
  - All mem_* outputs 0, except mem_gpr_we_=1.
  - busy=0.

Test Plan:
- Load, zero wait states: ex_en=1, op=01, ex_out=32'h0000_0104, bus_rdy_=0, rd_data=32'hDEAD_BEEF → bus_addr=30'h41, bus_rw=1, busy=0; next cycle mem_out=DEADBEEF, mem_en=1.
- Store, 2 wait states: op=10, ex_out=32'h200, wr_data=32'h1234_5678, bus_rdy_=1,1,0 → bus_as_ low for 3 cycles with bus_rw=0; busy=1,1,0; MEM/WB gets bubbles for 2 cycles, then the store.
- Misaligned load: ex_out=32'h0000_0102, op=01 → bus_as_ stays 1; mem_exp_code=5, mem_gpr_we_=1, mem_out=0.
- Non-memory op: op=00, ex_out=32'h0000_00AA, ex_gpr_we_=0, dst=7 → no bus strobe; mem_out=AA, mem_dst_addr=7, fwd_data=AA.
- Flush with a pending load in IDLE → no strobe, MEM/WB cleared. Flush during ACCESS → bus_as_ held until bus_rdy_=0, MEM/WB cleared.
- Reset asserted during ACCESS → bus_as_=1 and busy=0 without a clock edge; after release the FSM is in IDLE.
